// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types, widths and trellis helper for the K=3 Viterbi decoder
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam int DEC_W      = NUM_STATES;
   localparam int PM_W       = 8;

   typedef logic [1:0] state_t;

   typedef enum logic [1:0] {
      COLLECT,
      TRACE,
      OUTPUT
   } tbu_state_e;

   // Predecessor of state s given its survivor decision d.
   function automatic state_t pred(input state_t s, input logic d);
      return {s[0], d};
   endfunction

endpackage

// File: rtl/viterbi_min4.sv
// rtl/viterbi_min4.sv - 4-way unsigned argmin of path metrics, lowest index wins ties
// Only built when TBU_BEST_STATE_EN is defined.
`ifdef TBU_BEST_STATE_EN
module viterbi_min4
   import viterbi_pkg::*;
(
   input  logic [PM_W-1:0] pm0_i,
   input  logic [PM_W-1:0] pm1_i,
   input  logic [PM_W-1:0] pm2_i,
   input  logic [PM_W-1:0] pm3_i,
   output state_t          idx_o
);

   logic [PM_W-1:0] m01;
   logic [PM_W-1:0] m23;
   state_t          i01;
   state_t          i23;

   // Strict less-than keeps the lower index on equal metrics at every level.
   always_comb begin
      i01   = (pm1_i < pm0_i) ? 2'd1 : 2'd0;
      m01   = (pm1_i < pm0_i) ? pm1_i : pm0_i;
      i23   = (pm3_i < pm2_i) ? 2'd3 : 2'd2;
      m23   = (pm3_i < pm2_i) ? pm3_i : pm2_i;
      idx_o = (m23 < m01) ? i23 : i01;
   end

endmodule
`endif

// File: rtl/viterbi_tbu.sv
// rtl/viterbi_tbu.sv - survivor memory and traceback, decoded bits streamed in time order
// Optional TBU_BEST_STATE_EN: start traceback from the best final path metric instead of state 0.
module viterbi_tbu
   import viterbi_pkg::*;
#(
   parameter int MAX_LEN = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [DEC_W-1:0] dec_bits_i,
   input  logic             dec_valid_i,
   input  logic             dec_last_i,
   output logic             dec_ready_o,
   input  logic [PM_W-1:0]  pm_s0_i,
   input  logic [PM_W-1:0]  pm_s1_i,
   input  logic [PM_W-1:0]  pm_s2_i,
   input  logic [PM_W-1:0]  pm_s3_i,
   output logic             bit_o,
   output logic             bit_valid_o,
   output logic             bit_last_o,
   input  logic             bit_ready_i,
   output logic             busy_o,
   output logic             overflow_o
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_LEN - 1);

   tbu_state_e       state_q, state_d;
   logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
   state_t           cur_q, cur_d;
   logic             dec_ready_q, dec_ready_d;
   logic             bit_q, bit_d;
   logic             bit_valid_q, bit_valid_d;
   logic             bit_last_q, bit_last_d;
   logic             busy_q, busy_d;
   logic             overflow_q, overflow_d;

   logic [DEC_W-1:0] mem_q [MAX_LEN];
   logic [MAX_LEN-1:0] bitbuf_q;

   state_t           start_st;
   logic             dec_hs;
   logic [DEC_W-1:0] trace_word;
   logic [LEN_W-1:0] rd_next;

`ifdef TBU_BEST_STATE_EN
   viterbi_min4 u_min4 (
      .pm0_i (pm_s0_i),
      .pm1_i (pm_s1_i),
      .pm2_i (pm_s2_i),
      .pm3_i (pm_s3_i),
      .idx_o (start_st)
   );
`else
   // Zero-tail trellis always ends in state 0; metrics are not needed.
   logic unused_pm;
   assign unused_pm = ^{pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i};
   assign start_st  = '0;
`endif

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      len_d       = len_q;
      idx_d       = idx_q;
      rd_ptr_d    = rd_ptr_q;
      cur_d       = cur_q;
      bit_d       = bit_q;
      bit_valid_d = bit_valid_q;
      bit_last_d  = bit_last_q;
      overflow_d  = 1'b0;
      dec_hs      = dec_valid_i & dec_ready_q;
      trace_word  = mem_q[idx_q[IDX_W-1:0]];
      rd_next     = rd_ptr_q + LEN_ONE;

      unique case (state_q)
         COLLECT: begin
            if (dec_hs) begin
               wr_ptr_d = wr_ptr_q + LEN_ONE;
               if (dec_last_i || (wr_ptr_q == LEN_FULL)) begin
                  state_d    = TRACE;
                  len_d      = wr_ptr_q + LEN_ONE;
                  idx_d      = wr_ptr_q;
                  cur_d      = start_st;
                  wr_ptr_d   = '0;
                  overflow_d = ~dec_last_i;
               end
            end
         end
         TRACE: begin
            cur_d = pred(cur_q, trace_word[cur_q]);
            idx_d = idx_q - LEN_ONE;
            if (idx_q == '0) begin
               state_d  = OUTPUT;
               rd_ptr_d = '0;
            end
         end
         OUTPUT: begin
            // First OUTPUT cycle only loads the registered bit; then stream on handshakes.
            if (!bit_valid_q) begin
               bit_valid_d = 1'b1;
               bit_d       = bitbuf_q[rd_ptr_q[IDX_W-1:0]];
               bit_last_d  = (rd_ptr_q == len_q - LEN_ONE);
            end else if (bit_ready_i) begin
               if (bit_last_q) begin
                  bit_valid_d = 1'b0;
                  bit_last_d  = 1'b0;
                  state_d     = COLLECT;
               end else begin
                  rd_ptr_d   = rd_next;
                  bit_d      = bitbuf_q[rd_next[IDX_W-1:0]];
                  bit_last_d = (rd_next == len_q - LEN_ONE);
               end
            end
         end
         default: state_d = COLLECT;
      endcase

      dec_ready_d = (state_d == COLLECT);
      busy_d      = (state_d != COLLECT);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= COLLECT;
         wr_ptr_q    <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         rd_ptr_q    <= '0;
         cur_q       <= '0;
         dec_ready_q <= 1'b1;
         bit_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         bit_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         rd_ptr_q    <= rd_ptr_d;
         cur_q       <= cur_d;
         dec_ready_q <= dec_ready_d;
         bit_q       <= bit_d;
         bit_valid_q <= bit_valid_d;
         bit_last_q  <= bit_last_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage arrays carry no reset; their contents are rewritten every frame.
   always_ff @(posedge clk_i) begin
      if (dec_hs) begin
         mem_q[wr_ptr_q[IDX_W-1:0]] <= dec_bits_i;
      end
      if (state_q == TRACE) begin
         bitbuf_q[idx_q[IDX_W-1:0]] <= cur_q[1];
      end
   end

   assign dec_ready_o = dec_ready_q;
   assign bit_o       = bit_q;
   assign bit_valid_o = bit_valid_q;
   assign bit_last_o  = bit_last_q;
   assign busy_o      = busy_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_viterbi_tbu.sv
// tb/tb_viterbi_tbu.sv - randomized self-checking bench for viterbi_tbu against a traceback model
module tb_viterbi_tbu;

   localparam int MAX_LEN = 8;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic [3:0] dec_bits_i;
   logic       dec_valid_i;
   logic       dec_last_i;
   logic       dec_ready_o;
   logic [7:0] pm_v [4];
   logic       bit_o;
   logic       bit_valid_o;
   logic       bit_last_o;
   logic       bit_ready_i;
   logic       busy_o;
   logic       overflow_o;

   viterbi_tbu #(.MAX_LEN(MAX_LEN)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .dec_bits_i  (dec_bits_i),
      .dec_valid_i (dec_valid_i),
      .dec_last_i  (dec_last_i),
      .dec_ready_o (dec_ready_o),
      .pm_s0_i     (pm_v[0]),
      .pm_s1_i     (pm_v[1]),
      .pm_s2_i     (pm_v[2]),
      .pm_s3_i     (pm_v[3]),
      .bit_o       (bit_o),
      .bit_valid_o (bit_valid_o),
      .bit_last_o  (bit_last_o),
      .bit_ready_i (bit_ready_i),
      .busy_o      (busy_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0] tx_w [32];
   int  acc_cyc [32];
   bit  ovf_at [32];
   bit  busy_at [32];
   bit  rdy_at [32];
   bit  rx_bit [32];
   bit  rx_last [32];
   int  rx_cyc [32];
   bit  exp_bit [32];
   int  rx_n;
   int  first_valid_cyc;
   int  stall_err;
   int  ready_err;
   int  ovf_cnt;
   bit  tmo;
   bit  rdy_after;
   bit  val_after;

   always @(negedge clk) if (rst_ni === 1'b1 && overflow_o === 1'b1) ovf_cnt++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: walk the trellis backwards from the start state using the stored decisions.
   task automatic ref_decode(input int base, input int n, input int start);
      int cur = start;
      for (int i = n - 1; i >= 0; i--) begin
         exp_bit[base + i] = (cur >= 2);
         cur = (cur % 2) * 2 + ((tx_w[base + i] >> cur) & 1);
      end
   endtask

   function automatic int ref_start();
      int best = 0;
`ifdef TBU_BEST_STATE_EN
      for (int s = 1; s < 4; s++) if (pm_v[s] < pm_v[best]) best = s;
`endif
      return best;
   endfunction

   task automatic send_words(input int n, input bit last_flag);
      for (int i = 0; i < n; i++) begin
         bit r;
         int g;
         dec_bits_i  = tx_w[i];
         dec_valid_i = 1'b1;
         dec_last_i  = last_flag && (i == n - 1);
         g = 0;
         do begin
            r = dec_ready_o;
            step();
            g++;
         end while (!r && g < 500);
         if (!r) tmo = 1'b1;
         acc_cyc[i] = cyc;
         ovf_at[i]  = overflow_o;
         busy_at[i] = busy_o;
         rdy_at[i]  = dec_ready_o;
      end
      dec_valid_i = 1'b0;
      dec_last_i  = 1'b0;
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
   task automatic collect_bits(input int n, input int mode);
      int k = 0;
      bit pv = 0, pb = 0, pl = 0, prdy = 0;
      rx_n = 0; first_valid_cyc = -1; stall_err = 0; ready_err = 0;
      while (rx_n < n && k < 1000) begin
         bit v, b, l, r;
         case (mode)
            0: r = 1'b1;
            1: r = (k % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         bit_ready_i = r;
         v = bit_valid_o; b = bit_o; l = bit_last_o;
         if (v && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (v && pv && !prdy && (b !== pb || l !== pl)) stall_err++;
         if (v && dec_ready_o) ready_err++;
         pv = v; pb = b; pl = l; prdy = r;
         step();
         k++;
         if (v && r) begin
            rx_bit[rx_n] = b; rx_last[rx_n] = l; rx_cyc[rx_n] = cyc; rx_n++;
         end
      end
      bit_ready_i = 1'b0;
      if (rx_n < n) tmo = 1'b1;
      rdy_after = dec_ready_o;
      val_after = bit_valid_o;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; dec_valid_i = 1'b0; dec_last_i = 1'b0; dec_bits_i = '0; bit_ready_i = 1'b0;
      for (int s = 0; s < 4; s++) pm_v[s] = '0;
      repeat (3) step();
      checks++; if (dec_ready_o !== 1'b1) begin failures++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready_o); end
      checks++; if (bit_valid_o !== 1'b0) begin failures++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid_o); end
      checks++; if (bit_o !== 1'b0 || bit_last_o !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b%b exp=00", bit_o, bit_last_o); end
      checks++; if (busy_o !== 1'b0 || overflow_o !== 1'b0) begin failures++; $display("FAIL reset_busy_ovf got=%b%b exp=00", busy_o, overflow_o); end
      rst_ni = 1'b1;
      step();
   endtask

   task automatic test_zero_tail(input int mode);
      bit e [6] = '{1, 0, 1, 1, 0, 0};
      tx_w[0] = 4'b0000; tx_w[1] = 4'b0000; tx_w[2] = 4'b0100;
      tx_w[3] = 4'b0000; tx_w[4] = 4'b0010; tx_w[5] = 4'b0001;
      pm_v[0] = 8'd0; pm_v[1] = 8'd9; pm_v[2] = 8'd9; pm_v[3] = 8'd9;
      tmo = 1'b0;
      fork
         send_words(6, 1'b1);
         collect_bits(6, mode);
      join
      checks++; if (tmo) begin failures++; $display("FAIL zt%0d_timeout got=%0d bits exp=6", mode, rx_n); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (rx_bit[i] !== e[i] || rx_last[i] !== (i == 5)) begin
            failures++;
            $display("FAIL zt%0d_bit%0d got=%b/last%b exp=%b/last%b", mode, i, rx_bit[i], rx_last[i], e[i], i == 5);
         end
      end
      checks++; if (first_valid_cyc - acc_cyc[5] !== 7) begin failures++; $display("FAIL zt%0d_latency got=%0d exp=7", mode, first_valid_cyc - acc_cyc[5]); end
      checks++; if (busy_at[5] !== 1'b1 || rdy_at[5] !== 1'b0) begin failures++; $display("FAIL zt%0d_busy_ready got=%b%b exp=10", mode, busy_at[5], rdy_at[5]); end
      checks++; if (rdy_after !== 1'b1 || val_after !== 1'b0) begin failures++; $display("FAIL zt%0d_after got=ready%b/valid%b exp=ready1/valid0", mode, rdy_after, val_after); end
      checks++; if (ready_err !== 0) begin failures++; $display("FAIL zt%0d_ready_during_output got=%0d exp=0", mode, ready_err); end
      if (mode == 0) begin
         checks++; if (rx_cyc[5] - rx_cyc[0] !== 5) begin failures++; $display("FAIL zt_stream got=%0d exp=5", rx_cyc[5] - rx_cyc[0]); end
      end else begin
         checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_hold got=%0d exp=0", stall_err); end
      end
   endtask

   task automatic run_best(input int p0, input int p1, input int p2, input int p3, input bit [3:0] e, input string nm);
      tx_w[0] = 4'b0000; tx_w[1] = 4'b0000; tx_w[2] = 4'b0100; tx_w[3] = 4'b0000;
      pm_v[0] = 8'(p0); pm_v[1] = 8'(p1); pm_v[2] = 8'(p2); pm_v[3] = 8'(p3);
      tmo = 1'b0;
      fork
         send_words(4, 1'b1);
         collect_bits(4, 0);
      join
      checks++; if (tmo) begin failures++; $display("FAIL %s_timeout got=%0d exp=4", nm, rx_n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rx_bit[i] !== e[3 - i] || rx_last[i] !== (i == 3)) begin
            failures++;
            $display("FAIL %s_bit%0d got=%b/last%b exp=%b/last%b", nm, i, rx_bit[i], rx_last[i], e[3 - i], i == 3);
         end
      end
   endtask

   task automatic test_best_state();
`ifdef TBU_BEST_STATE_EN
      run_best(9, 7, 8, 2, 4'b1011, "best_s3");
`else
      run_best(9, 7, 8, 2, 4'b0000, "pm_ignored");
`endif
      run_best(3, 3, 5, 5, 4'b0000, "best_tie");
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 11; i++) tx_w[i] = 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++) pm_v[s] = 8'($urandom_range(0, 255));
      ref_decode(0, 8, ref_start());
      ref_decode(8, 3, ref_start());
      ovf_cnt = 0; tmo = 1'b0;
      fork
         send_words(11, 1'b1);
         collect_bits(11, 2);
      join
      checks++; if (tmo) begin failures++; $display("FAIL ovf_timeout got=%0d exp=11", rx_n); end
      checks++; if (ovf_cnt !== 1) begin failures++; $display("FAIL ovf_pulse_count got=%0d exp=1", ovf_cnt); end
      checks++; if (ovf_at[7] !== 1'b1 || ovf_at[6] !== 1'b0) begin failures++; $display("FAIL ovf_on_8th got=%b%b exp=01", ovf_at[6], ovf_at[7]); end
      checks++; if (acc_cyc[8] !== rx_cyc[7] + 1) begin failures++; $display("FAIL ovf_next_frame_accept got=%0d exp=%0d", acc_cyc[8], rx_cyc[7] + 1); end
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (rx_bit[i] !== exp_bit[i] || rx_last[i] !== (i == 7 || i == 10)) begin
            failures++;
            $display("FAIL ovf_bit%0d got=%b/last%b exp=%b/last%b", i, rx_bit[i], rx_last[i], exp_bit[i], i == 7 || i == 10);
         end
      end
   endtask

   task automatic test_len1();
      tx_w[0] = 4'b0000;
      pm_v[0] = 8'd0; pm_v[1] = 8'd1; pm_v[2] = 8'd2; pm_v[3] = 8'd3;
      tmo = 1'b0;
      fork
         send_words(1, 1'b1);
         collect_bits(1, 0);
      join
      checks++; if (tmo || rx_bit[0] !== 1'b0 || rx_last[0] !== 1'b1) begin failures++; $display("FAIL len1_bit got=%b/last%b exp=0/last1", rx_bit[0], rx_last[0]); end
      checks++; if (first_valid_cyc - acc_cyc[0] !== 2) begin failures++; $display("FAIL len1_latency got=%0d exp=2", first_valid_cyc - acc_cyc[0]); end
   endtask

   task automatic test_random(input int frames, input string nm);
      ovf_cnt = 0;
      for (int f = 0; f < frames; f++) begin
         int n = $urandom_range(1, MAX_LEN);
         for (int i = 0; i < n; i++) tx_w[i] = 4'($urandom_range(0, 15));
         for (int s = 0; s < 4; s++) pm_v[s] = 8'($urandom_range(0, 255));
         ref_decode(0, n, ref_start());
         tmo = 1'b0;
         fork
            send_words(n, 1'b1);
            collect_bits(n, 2);
         join
         checks++; if (tmo) begin failures++; $display("FAIL %s%0d_timeout got=%0d exp=%0d", nm, f, rx_n, n); end
         for (int i = 0; i < n; i++) begin
            checks++;
            if (rx_bit[i] !== exp_bit[i] || rx_last[i] !== (i == n - 1)) begin
               failures++;
               $display("FAIL %s%0d_bit%0d got=%b/last%b exp=%b/last%b", nm, f, i, rx_bit[i], rx_last[i], exp_bit[i], i == n - 1);
            end
         end
      end
      checks++; if (ovf_cnt !== 0) begin failures++; $display("FAIL %s_no_overflow got=%0d exp=0", nm, ovf_cnt); end
   endtask

   task automatic test_reset_mid_output();
      for (int i = 0; i < 6; i++) tx_w[i] = 4'($urandom_range(0, 15));
      tmo = 1'b0;
      fork
         send_words(6, 1'b1);
         collect_bits(2, 0);
      join
      checks++; if (tmo || bit_valid_o !== 1'b1) begin failures++; $display("FAIL rst_mid_precond got=%b exp=1", bit_valid_o); end
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      checks++; if (bit_valid_o !== 1'b0 || dec_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_state got=valid%b/ready%b exp=valid0/ready1", bit_valid_o, dec_ready_o); end
      checks++; if (busy_o !== 1'b0 || bit_last_o !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b%b exp=00", busy_o, bit_last_o); end
      bit_ready_i = 1'b1;
      repeat (4) step();
      bit_ready_i = 1'b0;
      checks++; if (bit_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_no_more_bits got=%b exp=0", bit_valid_o); end
      test_random(1, "post_rst");
   endtask

   initial begin
      test_reset();
      test_zero_tail(0);
      test_zero_tail(1);
      test_best_state();
      test_overflow();
      test_len1();
      test_reset_mid_output();
      test_random(8, "rand");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
